hexa7seg_leitor: RTL and testbench

HEXA7SEG_LEITOR -- requirements
Module: hexa7seg_leitor

---
 rtl/hexa7seg_leitor_pkg.sv | 61 ++++++
 rtl/hexa7seg_leitor_if.sv | 24 ++
 rtl/hexa7seg_tabela.sv | 40 ++++
 rtl/hexa7seg_leitor.sv | 116 +++++++++++
 tb/tb_hexa7seg_leitor.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/hexa7seg_leitor_pkg.sv
// rtl/hexa7seg_leitor_pkg.sv - seven-segment pattern constants, tipo and FSM encodings
// Shared by the reader and the hexa7seg display drivers so both agree on every glyph.
package hexa7seg_leitor_pkg;

   // Active-low, bit0=a .. bit5=f, bit6=g
   localparam logic [6:0] SEG_0       = 7'b1000000;
   localparam logic [6:0] SEG_1       = 7'b1111001;
   localparam logic [6:0] SEG_2       = 7'b0100100;
   localparam logic [6:0] SEG_3       = 7'b0110000;
   localparam logic [6:0] SEG_4       = 7'b0011001;
   localparam logic [6:0] SEG_5       = 7'b0010010;
   localparam logic [6:0] SEG_6       = 7'b0000010;
   localparam logic [6:0] SEG_7       = 7'b1111000;
   localparam logic [6:0] SEG_8       = 7'b0000000;
   localparam logic [6:0] SEG_9       = 7'b0010000;
   localparam logic [6:0] SEG_A       = 7'b0001000;
   localparam logic [6:0] SEG_B       = 7'b0000011;
   localparam logic [6:0] SEG_C       = 7'b1000110;
   localparam logic [6:0] SEG_D       = 7'b0100001;
   localparam logic [6:0] SEG_E       = 7'b0000110;
   localparam logic [6:0] SEG_F       = 7'b0001110;
   localparam logic [6:0] SEG_J       = 7'b1100001;
   localparam logic [6:0] SEG_TRACO   = 7'b0111111;
   localparam logic [6:0] SEG_APAGADO = 7'b1111111;

   typedef enum logic [1:0] {
      TIPO_HEX     = 2'b00,
      TIPO_J       = 2'b01,
      TIPO_TRACO   = 2'b10,
      TIPO_APAGADO = 2'b11
   } tipo_t;

   typedef enum logic [1:0] {
      OCIOSO,
      ESTABILIZANDO,
      ACEITO,
      INVALIDO
   } estado_t;

   function automatic logic [6:0] hex_para_seg(input logic [3:0] v);
      case (v)
         4'h0: return SEG_0;
         4'h1: return SEG_1;
         4'h2: return SEG_2;
         4'h3: return SEG_3;
         4'h4: return SEG_4;
         4'h5: return SEG_5;
         4'h6: return SEG_6;
         4'h7: return SEG_7;
         4'h8: return SEG_8;
         4'h9: return SEG_9;
         4'hA: return SEG_A;
         4'hB: return SEG_B;
         4'hC: return SEG_C;
         4'hD: return SEG_D;
         4'hE: return SEG_E;
         default: return SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/hexa7seg_leitor_if.sv
// rtl/hexa7seg_leitor_if.sv - sampling inputs and decoded outputs of the seven-segment reader
// The master drives habilita/seg and observes the decode; the slave is the reader itself.
interface hexa7seg_leitor_if;
   import hexa7seg_leitor_pkg::*;

   logic       habilita;
   logic [6:0] seg;
   logic [3:0] valor;
   tipo_t      tipo;
   logic       valido;
   logic       erro;
   logic       novo;

   modport master (
      output habilita, seg,
      input  valor, tipo, valido, erro, novo
   );

   modport slave (
      input  habilita, seg,
      output valor, tipo, valido, erro, novo
   );

endinterface

// File: rtl/hexa7seg_tabela.sv
// rtl/hexa7seg_tabela.sv - combinational lookup from a segment pattern to {reconhecido, tipo, valor}
// J, dash and blank report valor=0; any other code is unrecognized.
module hexa7seg_tabela
   import hexa7seg_leitor_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_reconhecido,
   output tipo_t      o_tipo,
   output logic [3:0] o_valor
);

   always_comb begin
      o_reconhecido = 1'b1;
      o_tipo        = TIPO_HEX;
      o_valor       = 4'h0;
      case (i_seg)
         SEG_0:       o_valor = 4'h0;
         SEG_1:       o_valor = 4'h1;
         SEG_2:       o_valor = 4'h2;
         SEG_3:       o_valor = 4'h3;
         SEG_4:       o_valor = 4'h4;
         SEG_5:       o_valor = 4'h5;
         SEG_6:       o_valor = 4'h6;
         SEG_7:       o_valor = 4'h7;
         SEG_8:       o_valor = 4'h8;
         SEG_9:       o_valor = 4'h9;
         SEG_A:       o_valor = 4'hA;
         SEG_B:       o_valor = 4'hB;
         SEG_C:       o_valor = 4'hC;
         SEG_D:       o_valor = 4'hD;
         SEG_E:       o_valor = 4'hE;
         SEG_F:       o_valor = 4'hF;
         SEG_J:       o_tipo  = TIPO_J;
         SEG_TRACO:   o_tipo  = TIPO_TRACO;
         SEG_APAGADO: o_tipo  = TIPO_APAGADO;
         default:     o_reconhecido = 1'b0;
      endcase
   end

endmodule

// File: rtl/hexa7seg_leitor.sv
// rtl/hexa7seg_leitor.sv - debounced seven-segment pattern reader
// A pattern is accepted after ESTAVEL consecutive identical enabled samples.
module hexa7seg_leitor
   import hexa7seg_leitor_pkg::*;
#(
   parameter int ESTAVEL = 4
)(
   input  logic               clock,
   input  logic               reset,
   hexa7seg_leitor_if.slave   bus
);

   localparam logic [3:0] LP_ESTAVEL = 4'(ESTAVEL);

   logic [6:0] r_amostra;
   logic [6:0] r_candidato;
   logic [6:0] r_aceito;
   logic [3:0] r_contador;
   estado_t    r_estado;
   logic [3:0] r_valor;
   tipo_t      r_tipo;
   logic       r_valido;
   logic       r_erro;
   logic       r_novo;

   logic       w_reconhecido;
   tipo_t      w_tipo;
   logic [3:0] w_valor;
   logic       w_igual;
   logic [3:0] w_cont_prox;
   logic       w_decide;

   hexa7seg_tabela u_tabela (
      .i_seg         (r_amostra),
      .o_reconhecido (w_reconhecido),
      .o_tipo        (w_tipo),
      .o_valor       (w_valor)
   );

   // A reload counts as the first stable sample, so ESTAVEL=1 decides on the reload itself
   always_comb begin
      w_igual     = (r_amostra == r_candidato);
      w_cont_prox = 4'd1;
      if (w_igual)
         w_cont_prox = (r_contador >= LP_ESTAVEL) ? LP_ESTAVEL : r_contador + 4'd1;
      w_decide = 1'b0;
      if (bus.habilita) begin
         if (r_estado == ESTABILIZANDO)
            w_decide = (w_cont_prox == LP_ESTAVEL);
         else if (r_estado == ACEITO || r_estado == INVALIDO)
            w_decide = !w_igual && (LP_ESTAVEL == 4'd1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_amostra   <= SEG_APAGADO;
         r_candidato <= SEG_APAGADO;
         r_aceito    <= SEG_APAGADO;
         r_contador  <= 4'd0;
         r_estado    <= OCIOSO;
         r_valor     <= 4'h0;
         r_tipo      <= TIPO_APAGADO;
         r_valido    <= 1'b0;
         r_erro      <= 1'b0;
         r_novo      <= 1'b0;
      end else begin
         r_novo <= 1'b0;
         if (bus.habilita) begin
            r_amostra <= bus.seg;
            case (r_estado)
               OCIOSO: begin
                  r_candidato <= r_amostra;
                  r_contador  <= 4'd1;
                  r_estado    <= ESTABILIZANDO;
               end
               ESTABILIZANDO: begin
                  r_candidato <= r_amostra;
                  r_contador  <= w_cont_prox;
               end
               ACEITO, INVALIDO: begin
                  if (!w_igual) begin
                     r_candidato <= r_amostra;
                     r_contador  <= 4'd1;
                     r_estado    <= ESTABILIZANDO;
                  end
               end
               default: r_estado <= OCIOSO;
            endcase
            if (w_decide) begin
               if (w_reconhecido) begin
                  r_estado <= ACEITO;
                  r_valor  <= w_valor;
                  r_tipo   <= w_tipo;
                  r_valido <= 1'b1;
                  r_erro   <= 1'b0;
                  r_aceito <= r_amostra;
                  // Settling back onto the pattern already shown is not news
                  r_novo   <= !(r_valido && (r_amostra == r_aceito));
               end else begin
                  r_estado <= INVALIDO;
                  r_valido <= 1'b0;
                  r_erro   <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.valor  = r_valor;
   assign bus.tipo   = r_tipo;
   assign bus.valido = r_valido;
   assign bus.erro   = r_erro;
   assign bus.novo   = r_novo;

endmodule

// File: tb/tb_hexa7seg_leitor.sv
// tb/tb_hexa7seg_leitor.sv - directed self-checking bench for hexa7seg_leitor
// Drives seg/habilita on the bus; a second ESTAVEL=1 instance shares the same stimulus.
module tb_hexa7seg_leitor;
   import hexa7seg_leitor_pkg::*;

   logic clock;
   logic reset;
   int   n_total;
   int   n_pass;
   int   p1, e1, p2, e2;

   hexa7seg_leitor_if bus ();
   hexa7seg_leitor_if bus2 ();

   assign bus2.seg      = bus.seg;
   assign bus2.habilita = bus.habilita;

   hexa7seg_leitor #(.ESTAVEL(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   hexa7seg_leitor #(.ESTAVEL(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2)
   );

   always #5 clock = ~clock;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_total++;
      if (obs === esp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
   endtask

   // Hold a pattern for n edges; report pulse count and edge of first novo for both instances
   task automatic segura(input logic [6:0] s, input int n,
                         output int q1, output int f1, output int q2, output int f2);
      bus.seg = s;
      q1 = 0; f1 = 0; q2 = 0; f2 = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clock);
         #1;
         if (bus.novo === 1'b1) begin
            q1++;
            if (f1 == 0) f1 = k;
         end
         if (bus2.novo === 1'b1) begin
            q2++;
            if (f2 == 0) f2 = k;
         end
      end
   endtask

   task automatic confere_reset(input string tag);
      verifica({tag, "_valor"},  32'(bus.valor),  32'h0);
      verifica({tag, "_tipo"},   32'(bus.tipo),   32'h3);
      verifica({tag, "_valido"}, 32'(bus.valido), 32'h0);
      verifica({tag, "_erro"},   32'(bus.erro),   32'h0);
      verifica({tag, "_novo"},   32'(bus.novo),   32'h0);
   endtask

   logic [6:0] padroes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   initial begin
      n_total      = 0;
      n_pass       = 0;
      clock        = 1'b0;
      reset        = 1'b1;
      bus.habilita = 1'b1;
      bus.seg      = 7'h7F;
      repeat (2) @(posedge clock);
      #1;
      confere_reset("rst");
      reset = 1'b0;

      // Digit 3 after reset
      segura(7'h30, 6, p1, e1, p2, e2);
      verifica("d3_pulsos", 32'(p1), 32'd1);
      verifica("d3_borda",  32'(e1), 32'd5);
      verifica("d3_valor",  32'(bus.valor), 32'h3);
      verifica("d3_tipo",   32'(bus.tipo), 32'h0);
      verifica("d3_valido", 32'(bus.valido), 32'h1);
      verifica("d3_erro",   32'(bus.erro), 32'h0);
      verifica("e1_pulsos", 32'(p2), 32'd1);
      verifica("e1_borda",  32'(e2), 32'd2);

      // Letter J then dash
      segura(7'h61, 6, p1, e1, p2, e2);
      verifica("j_pulsos",  32'(p1), 32'd1);
      verifica("j_borda",   32'(e1), 32'd5);
      verifica("j_tipo",    32'(bus.tipo), 32'h1);
      verifica("j_valor",   32'(bus.valor), 32'h0);
      verifica("j_valido",  32'(bus.valido), 32'h1);
      verifica("e1_j_borda", 32'(e2), 32'd2);
      segura(7'h3F, 6, p1, e1, p2, e2);
      verifica("tr_pulsos", 32'(p1), 32'd1);
      verifica("tr_borda",  32'(e1), 32'd5);
      verifica("tr_tipo",   32'(bus.tipo), 32'h2);
      verifica("tr_valor",  32'(bus.valor), 32'h0);

      // Short glitch around an accepted 3
      segura(7'h30, 6, p1, e1, p2, e2);
      verifica("g_pre_pulsos", 32'(p1), 32'd1);
      segura(7'h79, 2, p1, e1, p2, e2);
      verifica("g_meio_valido", 32'(bus.valido), 32'h1);
      verifica("g_meio_valor",  32'(bus.valor), 32'h3);
      segura(7'h30, 8, p1, e1, p2, e2);
      verifica("g_pulsos", 32'(p1), 32'd0);
      verifica("g_valor",  32'(bus.valor), 32'h3);
      verifica("g_valido", 32'(bus.valido), 32'h1);

      // Unrecognized pattern
      segura(7'h55, 5, p1, e1, p2, e2);
      verifica("inv_pulsos", 32'(p1), 32'd0);
      verifica("inv_erro",   32'(bus.erro), 32'h1);
      verifica("inv_valido", 32'(bus.valido), 32'h0);
      verifica("inv_valor",  32'(bus.valor), 32'h3);
      verifica("inv_tipo",   32'(bus.tipo), 32'h0);

      // Pause mid-count, junk on seg while paused
      segura(7'h12, 3, p1, e1, p2, e2);
      verifica("pa_pre_pulsos", 32'(p1), 32'd0);
      bus.habilita = 1'b0;
      segura(7'h00, 3, p1, e1, p2, e2);
      verifica("pa_pulsos", 32'(p1), 32'd0);
      verifica("pa_erro",   32'(bus.erro), 32'h1);
      verifica("pa_valor",  32'(bus.valor), 32'h3);
      bus.habilita = 1'b1;
      segura(7'h12, 3, p1, e1, p2, e2);
      verifica("pa_pos_pulsos", 32'(p1), 32'd1);
      verifica("pa_pos_borda",  32'(e1), 32'd2);
      verifica("pa_valor5",     32'(bus.valor), 32'h5);
      verifica("pa_valido",     32'(bus.valido), 32'h1);
      verifica("pa_erro0",      32'(bus.erro), 32'h0);

      // Asynchronous reset mid-count
      segura(7'h10, 3, p1, e1, p2, e2);
      #3;
      reset = 1'b1;
      #1;
      confere_reset("arst");
      @(posedge clock);
      #1;
      reset = 1'b0;
      segura(7'h10, 6, p1, e1, p2, e2);
      verifica("arst_pulsos", 32'(p1), 32'd1);
      verifica("arst_borda",  32'(e1), 32'd5);
      verifica("arst_valor",  32'(bus.valor), 32'h9);

      // Every hex glyph in turn
      for (int i = 0; i < 16; i++) begin
         segura(padroes[i], 5, p1, e1, p2, e2);
         verifica($sformatf("hex%0d_valor", i), 32'(bus.valor), 32'(i));
         verifica($sformatf("hex%0d_tipo", i),  32'(bus.tipo), 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
